icm_buffer_refill_client: RTL and testbench
===========================================

// Module: icm_buffer_refill_client
// PURPOSE
//  Initiator side of the ICM cache buffer get/set interface. Takes lookup requests from the
//  ICM manager, issues gets to the buffer, and returns hit data directly. On a miss it reads
//  the entry from host memory over DMA, writes it back with a set, and returns the fetched data.
//  Misses are blocking: one refill at a time, and responses always return in request order.
// PARAMETERS
//  CACHE_ADDR_WIDTH     20   cache-space entry address width
//  CACHE_ENTRY_WIDTH    256  entry data width
//  PHYSICAL_ADDR_WIDTH  64   host physical address width
//  REQ_TAG_WIDTH        8    requester tag width, carried opaquely
//  OUTSTANDING_MAX      4    max gets in flight (issued but lookup response not yet returned)
// PORTS
//  clk              in   1    clock
//  rst              in   1    asynchronous reset, active-high
//  lkp_req_valid    in   1    lookup request
//  lkp_req_head     in   T+P+A  {req_tag, phy_addr, cache_addr}; T/P/A = tag/phys/cache addr widths
//  lkp_req_ready    out  1
//  lkp_rsp_valid    out  1    lookup response
//  lkp_rsp_head     out  T+A  {req_tag, cache_addr}
//  lkp_rsp_data     out  CACHE_ENTRY_WIDTH
//  lkp_rsp_ready    in   1
//  get_req_valid/head/ready  out/out/in  1/T+P+A/1  get to buffer, head = lkp_req_head
//  get_rsp_valid/head/data/ready  in/in/in/out  1/1+T+P+A/CACHE_ENTRY_WIDTH/1  head MSB = hit
//  set_req_valid/head/data/ready  out/out/out/in  1/A/CACHE_ENTRY_WIDTH/1  refill write
//  dma_rd_req_valid/addr/ready  out/out/in  1/P/1  host read of one entry
//  dma_rd_rsp_valid/data/ready  in/in/out  1/CACHE_ENTRY_WIDTH/1
// BEHAVIOUR
//  Handshake: transfer when valid&ready. Once a valid is raised, it and its payload hold until accepted.
//  Request path is combinational pass-through:
//   get_req_valid = lkp_req_valid & (cnt<OUTSTANDING_MAX); lkp_req_ready = get_req_ready & (cnt<MAX).
//  cnt (log2(MAX)+1 bits): +1 on a get_req fire, -1 on a lkp_rsp fire; simultaneous -> unchanged.
//  Response FSM, with registers for the captured head and data:
//   IDLE: get_rsp_ready=1. On a fire, capture head and data. hit=1 -> HIT_OUT; hit=0 -> DMA_REQ.
//   HIT_OUT: lkp_rsp_valid=1 with the captured tag/addr/data; on fire -> IDLE.
//   DMA_REQ: dma_rd_req_valid=1, addr = captured phy_addr; on fire -> DMA_WAIT.
//   DMA_WAIT: dma_rd_rsp_ready=1; on fire, capture data -> FILL.
//   FILL: set_req_valid and lkp_rsp_valid both asserted, carrying the same DMA data.
//    Each drops independently once it fires. When both have fired -> IDLE.
//    set_req_head = captured cache_addr.
//  get_rsp_ready=0 in every state except IDLE (blocking miss); the buffer holds later responses.
//  Latency: hit response valid 1 cycle after the get_rsp fire. Miss response valid 1 cycle after the dma_rd_rsp fire.
//  From IDLE back to IDLE with no backpressure: 2 cycles on a hit.
//  dma_rd_rsp_valid outside DMA_WAIT is ignored (ready=0).
//  Reset (async, any state): FSM->IDLE, cnt=0, captured regs=0. All valids=0.
//   get_rsp_ready=0 and dma_rd_rsp_ready=0 while rst is high. In-flight requests are dropped.
//  All outputs are 0 during reset, except the combinational pass-through heads.
// TESTING
//  1 hit: lkp tag=0x11, addr=0x00040, buffer returns hit=1 data=D1 -> lkp_rsp tag 0x11 data D1, no DMA, no set.
//  2 miss: hit=0, phy=0x1000_0000 -> dma addr 0x1000_0000; DMA data D2 ->
//    set_req addr 0x00040 data D2 and lkp_rsp data D2; cnt returns to 0.
//  3 FILL split: set_req_ready=0 for 5 cycles, lkp_rsp_ready=1 -> lkp_rsp fires first,
//    set_req held stable, FSM leaves FILL only after set fires.
//  4 outstanding limit: 5 back-to-back lkp_req, get_rsp stalled -> 4 accepted, 5th held;
//    accepted after the first lkp_rsp fires.
//  5 ordering: miss then hit queued -> hit rsp is not consumed until miss lkp_rsp fires; output order preserved.
//  6 reset in DMA_WAIT: rst pulse -> all valids 0 asynchronously, cnt=0.
//    A later hit lookup completes normally.

Source files
------------

// File: rtl/icm_buffer_refill_client.sv
// rtl/icm_buffer_refill_client.sv - ICM buffer get/set initiator with blocking miss refill over DMA
// Lookups pass straight through as gets; responses are serialised by one FSM so order is preserved.
module icm_buffer_refill_client #(
  parameter int CACHE_ADDR_WIDTH    = 20,
  parameter int CACHE_ENTRY_WIDTH   = 256,
  parameter int PHYSICAL_ADDR_WIDTH = 64,
  parameter int REQ_TAG_WIDTH       = 8,
  parameter int OUTSTANDING_MAX     = 4
) (
  input  logic                                                          clk,
  input  logic                                                          rst,
  input  logic                                                          lkp_req_valid,
  input  logic [REQ_TAG_WIDTH+PHYSICAL_ADDR_WIDTH+CACHE_ADDR_WIDTH-1:0] lkp_req_head,
  output logic                                                          lkp_req_ready,
  output logic                                                          lkp_rsp_valid,
  output logic [REQ_TAG_WIDTH+CACHE_ADDR_WIDTH-1:0]                     lkp_rsp_head,
  output logic [CACHE_ENTRY_WIDTH-1:0]                                  lkp_rsp_data,
  input  logic                                                          lkp_rsp_ready,
  output logic                                                          get_req_valid,
  output logic [REQ_TAG_WIDTH+PHYSICAL_ADDR_WIDTH+CACHE_ADDR_WIDTH-1:0] get_req_head,
  input  logic                                                          get_req_ready,
  input  logic                                                          get_rsp_valid,
  input  logic [REQ_TAG_WIDTH+PHYSICAL_ADDR_WIDTH+CACHE_ADDR_WIDTH:0]   get_rsp_head,
  input  logic [CACHE_ENTRY_WIDTH-1:0]                                  get_rsp_data,
  output logic                                                          get_rsp_ready,
  output logic                                                          set_req_valid,
  output logic [CACHE_ADDR_WIDTH-1:0]                                   set_req_head,
  output logic [CACHE_ENTRY_WIDTH-1:0]                                  set_req_data,
  input  logic                                                          set_req_ready,
  output logic                                                          dma_rd_req_valid,
  output logic [PHYSICAL_ADDR_WIDTH-1:0]                                dma_rd_req_addr,
  input  logic                                                          dma_rd_req_ready,
  input  logic                                                          dma_rd_rsp_valid,
  input  logic [CACHE_ENTRY_WIDTH-1:0]                                  dma_rd_rsp_data,
  output logic                                                          dma_rd_rsp_ready
);

  localparam int HW    = REQ_TAG_WIDTH + PHYSICAL_ADDR_WIDTH + CACHE_ADDR_WIDTH;
  localparam int CNT_W = $clog2(OUTSTANDING_MAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT_OUT,
    S_DMA_REQ,
    S_DMA_WAIT,
    S_FILL
  } state_t;

  state_t                         state, state_nxt;
  logic [CNT_W-1:0]               cnt;
  logic [HW-1:0]                  cap_head;
  logic [CACHE_ENTRY_WIDTH-1:0]   cap_data;
  logic                           set_done, rsp_done;
  logic                           can_issue, get_fire, rsp_fire;
  logic                           get_rsp_fire, dma_rsp_fire, set_fire;

  // Reset gating keeps the request handshake quiet while rst is held.
  assign can_issue     = (cnt < CNT_W'(OUTSTANDING_MAX)) & ~rst;
  assign get_req_valid = lkp_req_valid & can_issue;
  assign lkp_req_ready = get_req_ready & can_issue;
  assign get_req_head  = lkp_req_head;

  assign get_fire     = get_req_valid & get_req_ready;
  assign rsp_fire     = lkp_rsp_valid & lkp_rsp_ready;
  assign get_rsp_fire = get_rsp_valid & get_rsp_ready;
  assign dma_rsp_fire = dma_rd_rsp_valid & dma_rd_rsp_ready;
  assign set_fire     = set_req_valid & set_req_ready;

  assign lkp_rsp_head    = {cap_head[HW-1 -: REQ_TAG_WIDTH], cap_head[CACHE_ADDR_WIDTH-1:0]};
  assign lkp_rsp_data    = cap_data;
  assign set_req_head    = cap_head[CACHE_ADDR_WIDTH-1:0];
  assign set_req_data    = cap_data;
  assign dma_rd_req_addr = cap_head[CACHE_ADDR_WIDTH +: PHYSICAL_ADDR_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({get_fire, rsp_fire})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cap_head <= '0;
      cap_data <= '0;
      set_done <= 1'b0;
      rsp_done <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && get_rsp_fire) begin
        cap_head <= get_rsp_head[HW-1:0];
        cap_data <= get_rsp_data;
      end
      if (state == S_DMA_WAIT && dma_rsp_fire) begin
        cap_data <= dma_rd_rsp_data;
        set_done <= 1'b0;
        rsp_done <= 1'b0;
      end
      // In FILL the set and the response retire independently.
      if (state == S_FILL) begin
        if (set_fire) set_done <= 1'b1;
        if (rsp_fire) rsp_done <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    get_rsp_ready    = 1'b0;
    lkp_rsp_valid    = 1'b0;
    set_req_valid    = 1'b0;
    dma_rd_req_valid = 1'b0;
    dma_rd_rsp_ready = 1'b0;
    case (state)
      S_IDLE: begin
        get_rsp_ready = ~rst;
        if (get_rsp_valid & ~rst)
          state_nxt = get_rsp_head[HW] ? S_HIT_OUT : S_DMA_REQ;
      end
      S_HIT_OUT: begin
        lkp_rsp_valid = 1'b1;
        if (lkp_rsp_ready) state_nxt = S_IDLE;
      end
      S_DMA_REQ: begin
        dma_rd_req_valid = 1'b1;
        if (dma_rd_req_ready) state_nxt = S_DMA_WAIT;
      end
      S_DMA_WAIT: begin
        dma_rd_rsp_ready = 1'b1;
        if (dma_rd_rsp_valid) state_nxt = S_FILL;
      end
      S_FILL: begin
        set_req_valid = ~set_done;
        lkp_rsp_valid = ~rsp_done;
        if ((set_done | set_req_ready) & (rsp_done | lkp_rsp_ready)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_icm_buffer_refill_client.sv
// tb/tb_icm_buffer_refill_client.sv - self-checking bench for icm_buffer_refill_client
// Buffer and host memory are played by the bench; a transaction-level model predicts every handshake.
module tb_icm_buffer_refill_client;
  localparam int T = 8, P = 64, A = 20, W = 256, HW = T + P + A;

  logic clk = 0, rst = 1;
  logic lkp_req_valid = 0; logic [HW-1:0] lkp_req_head = '0; logic lkp_req_ready;
  logic lkp_rsp_valid; logic [T+A-1:0] lkp_rsp_head; logic [W-1:0] lkp_rsp_data; logic lkp_rsp_ready = 1;
  logic get_req_valid; logic [HW-1:0] get_req_head; logic get_req_ready = 1;
  logic get_rsp_valid = 0; logic [HW:0] get_rsp_head = '0; logic [W-1:0] get_rsp_data = '0; logic get_rsp_ready;
  logic set_req_valid; logic [A-1:0] set_req_head; logic [W-1:0] set_req_data; logic set_req_ready = 1;
  logic dma_rd_req_valid; logic [P-1:0] dma_rd_req_addr; logic dma_rd_req_ready = 1;
  logic dma_rd_rsp_valid = 0; logic [W-1:0] dma_rd_rsp_data = '0; logic dma_rd_rsp_ready;

  icm_buffer_refill_client dut (
    .clk(clk), .rst(rst),
    .lkp_req_valid(lkp_req_valid), .lkp_req_head(lkp_req_head), .lkp_req_ready(lkp_req_ready),
    .lkp_rsp_valid(lkp_rsp_valid), .lkp_rsp_head(lkp_rsp_head), .lkp_rsp_data(lkp_rsp_data),
    .lkp_rsp_ready(lkp_rsp_ready),
    .get_req_valid(get_req_valid), .get_req_head(get_req_head), .get_req_ready(get_req_ready),
    .get_rsp_valid(get_rsp_valid), .get_rsp_head(get_rsp_head), .get_rsp_data(get_rsp_data),
    .get_rsp_ready(get_rsp_ready),
    .set_req_valid(set_req_valid), .set_req_head(set_req_head), .set_req_data(set_req_data),
    .set_req_ready(set_req_ready),
    .dma_rd_req_valid(dma_rd_req_valid), .dma_rd_req_addr(dma_rd_req_addr), .dma_rd_req_ready(dma_rd_req_ready),
    .dma_rd_rsp_valid(dma_rd_rsp_valid), .dma_rd_rsp_data(dma_rd_rsp_data), .dma_rd_rsp_ready(dma_rd_rsp_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic hit; logic [HW-1:0] head; } gq_t;
  typedef struct packed { logic [T+A-1:0] head; logic [W-1:0] data; } rsp_t;
  typedef struct packed { logic [A-1:0] addr; logic [W-1:0] data; } set_t;

  gq_t        gq[$];
  logic [P-1:0] dq[$];
  rsp_t       exp_rsp_q[$];
  set_t       exp_set_q[$];
  logic [P-1:0] exp_dma_q[$];
  int         acc_cyc[$], rsp_fire_cyc[$], grsp_cyc[$];
  logic [T-1:0] rsp_tag_q[$];

  int checks = 0, failures = 0, cyc = 0, out_cnt = 0;
  int set_fire_cyc = 0, dma_fires = 0, set_fires = 0;
  bit cur_hit = 0, buf_stall = 0, dma_stall = 0;
  bit m_need_rsp = 0, m_need_set = 0, m_dma_need = 0, m_dma_pend = 0;
  logic [T+A-1:0] last_rsp_head = '0; logic [W-1:0] last_rsp_data = '0;
  logic [A-1:0] last_set_addr = '0; logic [W-1:0] last_set_data = '0;
  logic [P-1:0] last_dma_addr = '0;

  function automatic logic [W-1:0] buf_data(input logic [A-1:0] a);
    return {8{32'hD1D1_0000 | {12'h000, a}}};
  endfunction

  function automatic logic [W-1:0] host_data(input logic [P-1:0] p);
    return {4{p ^ 64'hD2D2_0000_0000_0000}};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  // Compare process: predict every handshake from the outstanding transactions.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst) begin
      chk("get_req_valid", get_req_valid, lkp_req_valid && out_cnt < 4);
      chk("lkp_req_ready", lkp_req_ready, get_req_ready && out_cnt < 4);
      chk("get_req_head", get_req_head, lkp_req_head);
      chk("get_rsp_ready", get_rsp_ready, !(m_need_rsp || m_need_set));
      chk("lkp_rsp_valid", lkp_rsp_valid, m_need_rsp && !m_dma_need && !m_dma_pend);
      chk("set_req_valid", set_req_valid, m_need_set && !m_dma_need && !m_dma_pend);
      chk("dma_rd_req_valid", dma_rd_req_valid, m_dma_need);
      chk("dma_rd_rsp_ready", dma_rd_rsp_ready, m_dma_pend);
      if (lkp_rsp_valid && exp_rsp_q.size() > 0) begin
        chk("lkp_rsp_head", lkp_rsp_head, exp_rsp_q[0].head);
        chk("lkp_rsp_data", lkp_rsp_data, exp_rsp_q[0].data);
      end
      if (set_req_valid && exp_set_q.size() > 0) begin
        chk("set_req_head", set_req_head, exp_set_q[0].addr);
        chk("set_req_data", set_req_data, exp_set_q[0].data);
      end
      if (dma_rd_req_valid && exp_dma_q.size() > 0)
        chk("dma_rd_req_addr", dma_rd_req_addr, exp_dma_q[0]);

      if (get_req_valid && get_req_ready) begin
        gq.push_back({cur_hit, get_req_head});
        exp_rsp_q.push_back({get_req_head[HW-1 -: T], get_req_head[A-1:0],
                             cur_hit ? buf_data(get_req_head[A-1:0]) : host_data(get_req_head[A +: P])});
        if (!cur_hit) begin
          exp_set_q.push_back({get_req_head[A-1:0], host_data(get_req_head[A +: P])});
          exp_dma_q.push_back(get_req_head[A +: P]);
        end
        out_cnt++;
        acc_cyc.push_back(cyc);
      end
      if (lkp_rsp_valid && lkp_rsp_ready) begin
        out_cnt--;
        if (exp_rsp_q.size() > 0) void'(exp_rsp_q.pop_front());
        m_need_rsp = 0;
        rsp_fire_cyc.push_back(cyc);
        rsp_tag_q.push_back(lkp_rsp_head[T+A-1 -: T]);
        last_rsp_head = lkp_rsp_head;
        last_rsp_data = lkp_rsp_data;
      end
      if (get_rsp_valid && get_rsp_ready && gq.size() > 0) begin
        m_need_rsp = 1;
        m_need_set = !gq[0].hit;
        m_dma_need = !gq[0].hit;
        void'(gq.pop_front());
        grsp_cyc.push_back(cyc);
      end
      if (dma_rd_req_valid && dma_rd_req_ready) begin
        dq.push_back(dma_rd_req_addr);
        if (exp_dma_q.size() > 0) void'(exp_dma_q.pop_front());
        m_dma_need = 0;
        m_dma_pend = 1;
        dma_fires++;
        last_dma_addr = dma_rd_req_addr;
      end
      if (dma_rd_rsp_valid && dma_rd_rsp_ready) begin
        if (dq.size() > 0) void'(dq.pop_front());
        m_dma_pend = 0;
      end
      if (set_req_valid && set_req_ready) begin
        m_need_set = 0;
        if (exp_set_q.size() > 0) void'(exp_set_q.pop_front());
        set_fire_cyc = cyc;
        set_fires++;
        last_set_addr = set_req_head;
        last_set_data = set_req_data;
      end
    end
  end

  // Buffer and host-memory responders.
  initial forever begin
    @(posedge clk);
    #1;
    get_rsp_valid = !rst && !buf_stall && gq.size() > 0;
    if (gq.size() > 0) begin
      get_rsp_head = {gq[0].hit, gq[0].head};
      get_rsp_data = gq[0].hit ? buf_data(gq[0].head[A-1:0]) : ~buf_data(gq[0].head[A-1:0]);
    end
    dma_rd_rsp_valid = !rst && !dma_stall && dq.size() > 0;
    if (dq.size() > 0) dma_rd_rsp_data = host_data(dq[0]);
    else               dma_rd_rsp_data = {8{32'hBAD0_BAD0}};
  end

  task automatic send(input logic [T-1:0] tag, input logic [P-1:0] phy, input logic [A-1:0] addr, input bit hit);
    int n;
    @(posedge clk);
    #1;
    cur_hit = hit;
    lkp_req_head = {tag, phy, addr};
    lkp_req_valid = 1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (lkp_req_ready) break;
    end
    if (n == 200) fail_timeout("send");
    @(posedge clk);
    #1;
    lkp_req_valid = 0;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      #1;
      if (out_cnt == 0 && gq.size() == 0 && !m_need_rsp && !m_need_set && exp_rsp_q.size() == 0) break;
    end
    if (n == 300) fail_timeout("wait_idle");
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_lkp_rsp_valid"}, lkp_rsp_valid, 0);
    chk({tag, "_set_req_valid"}, set_req_valid, 0);
    chk({tag, "_dma_rd_req_valid"}, dma_rd_req_valid, 0);
    chk({tag, "_get_req_valid"}, get_req_valid, 0);
    chk({tag, "_lkp_req_ready"}, lkp_req_ready, 0);
    chk({tag, "_get_rsp_ready"}, get_rsp_ready, 0);
    chk({tag, "_dma_rd_rsp_ready"}, dma_rd_rsp_ready, 0);
    chk({tag, "_lkp_rsp_data"}, lkp_rsp_data, 0);
    chk({tag, "_set_req_head"}, set_req_head, 0);
    chk({tag, "_dma_rd_req_addr"}, dma_rd_req_addr, 0);
  endtask

  initial begin
    int abase, rbase, gbase, n;
    #2;
    lkp_req_valid = 1;
    #1;
    rst_checks("por");
    lkp_req_valid = 0;
    @(posedge clk);
    #3;
    rst = 0;

    // 1: hit
    send(8'h11, 64'h0, 20'h00040, 1);
    wait_idle();
    chk("t1_rsp_head", last_rsp_head, {8'h11, 20'h00040});
    chk("t1_rsp_data", last_rsp_data, {8{32'hD1D1_0040}});
    chk("t1_no_dma", dma_fires, 0);
    chk("t1_no_set", set_fires, 0);

    // 2: miss with refill
    send(8'h22, 64'h1000_0000, 20'h00040, 0);
    wait_idle();
    chk("t2_dma_addr", last_dma_addr, 64'h1000_0000);
    chk("t2_set_addr", last_set_addr, 20'h00040);
    chk("t2_set_data", last_set_data, {4{64'hD2D2_0000_1000_0000}});
    chk("t2_rsp_data", last_rsp_data, {4{64'hD2D2_0000_1000_0000}});
    chk("t2_rsp_head", last_rsp_head, {8'h22, 20'h00040});
    chk("t2_cnt_zero", lkp_req_ready, 1);

    // 3: FILL split, set backpressured
    @(posedge clk);
    #1;
    set_req_ready = 0;
    send(8'h33, 64'h3000_0000, 20'h00333, 0);
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (set_req_valid) break;
    end
    if (n == 100) fail_timeout("t3_set_valid");
    repeat (5) @(posedge clk);
    #1;
    set_req_ready = 1;
    wait_idle();
    chk("t3_gap", set_fire_cyc - rsp_fire_cyc[$], 5);
    chk("t3_set_data", last_set_data, {4{64'hD2D2_0000_3000_0000}});

    // 4: outstanding limit
    abase = acc_cyc.size();
    rbase = rsp_fire_cyc.size();
    buf_stall = 1;
    fork
      for (int i = 0; i < 5; i++) send(8'h40 + 8'(i), 64'h0, 20'h00400 + 20'(i), 1);
      begin
        repeat (20) @(negedge clk);
        chk("t4_accepted_while_stalled", acc_cyc.size() - abase, 4);
        buf_stall = 0;
      end
    join
    wait_idle();
    chk("t4_accepted_total", acc_cyc.size() - abase, 5);
    if (acc_cyc.size() - abase == 5 && rsp_fire_cyc.size() > rbase)
      chk("t4_fifth_after_rsp", acc_cyc[abase+4] > rsp_fire_cyc[rbase], 1);
    else fail_timeout("t4_fifth_after_rsp");

    // 5: ordering, hit queued behind miss
    rbase = rsp_tag_q.size();
    gbase = grsp_cyc.size();
    abase = rsp_fire_cyc.size();
    send(8'h51, 64'h2000_0000, 20'h00100, 0);
    send(8'h52, 64'h0, 20'h00200, 1);
    wait_idle();
    if (rsp_tag_q.size() - rbase == 2 && grsp_cyc.size() - gbase == 2) begin
      chk("t5_order0", rsp_tag_q[rbase], 8'h51);
      chk("t5_order1", rsp_tag_q[rbase+1], 8'h52);
      chk("t5_hit_held", grsp_cyc[gbase+1] > rsp_fire_cyc[abase], 1);
    end else fail_timeout("t5_responses");
    chk("t5_last_data", last_rsp_data, {8{32'hD1D1_0200}});

    // 6: reset while waiting on DMA
    dma_stall = 1;
    send(8'h60, 64'h6000_0000, 20'h00600, 0);
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (m_dma_pend) break;
    end
    if (n == 100) fail_timeout("t6_dma_wait");
    repeat (3) @(posedge clk);
    #3;
    rst = 1;
    lkp_req_valid = 1;
    gq.delete(); dq.delete(); exp_rsp_q.delete(); exp_set_q.delete(); exp_dma_q.delete();
    m_need_rsp = 0; m_need_set = 0; m_dma_need = 0; m_dma_pend = 0; out_cnt = 0;
    #1;
    rst_checks("t6");
    @(posedge clk);
    #1;
    lkp_req_valid = 0;
    dma_stall = 0;
    @(posedge clk);
    #3;
    rst = 0;
    send(8'h66, 64'h0, 20'h00077, 1);
    wait_idle();
    chk("t6_after_head", last_rsp_head, {8'h66, 20'h00077});
    chk("t6_after_data", last_rsp_data, {8{32'hD1D1_0077}});

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
